// File: rtl/d2d_pkg.sv
// Shared types for the die-to-die TX scheduler: index type, FSM states and link sideband.
package d2d_pkg;

    localparam int DEF_CHANNELS = 2;
    localparam int DEF_FLIT_W   = 64;
    localparam int DEF_CREDITS  = 4;
    localparam int CH_IDX_MAX_W = 8;

    typedef logic [CH_IDX_MAX_W-1:0] ch_idx_t;

    typedef enum logic {IDLE, LOCKED} sched_state_t;

    typedef struct packed {
        logic    head;
        logic    tail;
        ch_idx_t ch;
    } flit_sb_t;

endpackage

// File: rtl/d2d_credit_counter.sv
// Far-side credit tracker for one channel: -1 per sent flit, +1 per returned credit, saturates at full.
module d2d_credit_counter
    import d2d_pkg::*;
#(
    parameter int CREDITS = DEF_CREDITS
) (
    input  logic clk,
    input  logic rstn,
    input  logic inc,
    input  logic dec,
    output logic has_credit
);

    localparam int CNT_W = $clog2(CREDITS + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(CREDITS);

    logic [CNT_W-1:0] credits;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            credits <= FULL;
        end else if (inc && !dec && credits != FULL) begin
            credits <= credits + 1'b1;
        end else if (dec && !inc) begin
            credits <= credits - 1'b1;
        end
    end

    assign has_credit = (credits != '0);

`ifndef SYNTHESIS
    a_no_overflow_ret: assert property (@(posedge clk) disable iff (!rstn)
        !(inc && !dec && credits == FULL));
    a_in_range: assert property (@(posedge clk) disable iff (!rstn) credits <= FULL);
    a_no_underflow: assert property (@(posedge clk) disable iff (!rstn)
        !(dec && credits == '0));
`endif

endmodule

// File: rtl/d2d_tx_scheduler.sv
// Round-robin wormhole scheduler sharing one D2D TX link between plane channels.
// Optional per-channel sent-flit counters when D2D_SCHED_STATS_EN is defined.
module d2d_tx_scheduler
    import d2d_pkg::*;
#(
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int FLIT_W   = DEF_FLIT_W,
    parameter int CREDITS  = DEF_CREDITS
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic [CHANNELS-1:0]          in_valid,
    input  logic [CHANNELS*FLIT_W-1:0]   in_flit,
    input  logic [CHANNELS-1:0]          in_head,
    input  logic [CHANNELS-1:0]          in_tail,
    output logic [CHANNELS-1:0]          in_ready,
    input  logic [CHANNELS-1:0]          credit_ret,
    output logic                         link_valid,
    output logic [FLIT_W-1:0]            link_flit,
    output logic [$clog2(CHANNELS)-1:0]  link_ch,
    output logic                         link_tail,
    input  logic                         link_ready,
    output logic [CHANNELS*32-1:0]       stats_flits
);

    localparam int CH_W = $clog2(CHANNELS);

    logic [CHANNELS-1:0][FLIT_W-1:0] flit_arr;
    logic [CHANNELS-1:0]             has_credit;
    logic [CHANNELS-1:0]             elig;
    logic [CHANNELS-1:0]             grant;
    sched_state_t                    state, state_nxt;
    logic [CH_W-1:0]                 lock_ch, ptr, xfer_ch;
    logic                            out_free, xfer;
    flit_sb_t                        link_sb;

    assign flit_arr = in_flit;

    d2d_credit_counter #(.CREDITS(CREDITS)) u_cc [CHANNELS-1:0] (
        .clk        (clk),
        .rstn       (rstn),
        .inc        (credit_ret),
        .dec        (in_ready),
        .has_credit (has_credit)
    );

    assign elig     = in_valid & has_credit;
    assign out_free = !link_valid || link_ready;
    // rstn gate keeps in_ready low while reset is asserted, regardless of inputs
    assign in_ready = grant & {CHANNELS{out_free & rstn}};
    assign xfer     = |in_ready;

    always_comb begin : arb
        int   j;
        logic found;
        grant = '0;
        found = 1'b0;
        j     = 0;
        if (state == IDLE) begin
            for (int k = 0; k < CHANNELS; k++) begin
                j = int'(ptr) + k;
                if (j >= CHANNELS) j = j - CHANNELS;
                if (!found && elig[j] && in_head[j]) begin
                    grant[j] = 1'b1;
                    found    = 1'b1;
                end
            end
        end else begin
            grant[lock_ch] = elig[lock_ch];
        end
    end

    always_comb begin
        xfer_ch = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (in_ready[i]) xfer_ch = CH_W'(i);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (xfer && !in_tail[xfer_ch]) state_nxt = LOCKED;
            LOCKED:  if (xfer && in_tail[xfer_ch])  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            lock_ch <= '0;
            ptr     <= '0;
        end else begin
            state <= state_nxt;
            if (xfer && state == IDLE) lock_ch <= xfer_ch;
            // finished packet's channel drops to lowest priority
            if (xfer && in_tail[xfer_ch])
                ptr <= (xfer_ch == CH_W'(CHANNELS - 1)) ? '0 : xfer_ch + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            link_valid <= 1'b0;
            link_flit  <= '0;
            link_sb    <= '0;
        end else if (xfer) begin
            link_valid <= 1'b1;
            link_flit  <= flit_arr[xfer_ch];
            link_sb    <= '{head: in_head[xfer_ch], tail: in_tail[xfer_ch], ch: ch_idx_t'(xfer_ch)};
        end else if (link_ready) begin
            link_valid <= 1'b0;
        end
    end

    assign link_ch   = link_sb.ch[CH_W-1:0];
    assign link_tail = link_sb.tail;

`ifdef D2D_SCHED_STATS_EN
    logic [CHANNELS-1:0][31:0] stats_q;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_stats
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn)            stats_q[g] <= '0;
            else if (in_ready[g]) stats_q[g] <= stats_q[g] + 32'd1;
        end
    end

    assign stats_flits = stats_q;
`else
    assign stats_flits = '0;
`endif

`ifndef SYNTHESIS
    a_onehot_ready: assert property (@(posedge clk) disable iff (!rstn) $onehot0(in_ready));
    a_credit_on_xfer: assert property (@(posedge clk) disable iff (!rstn)
        (in_ready & ~has_credit) == '0);
    a_head_at_idle: assert property (@(posedge clk) disable iff (!rstn)
        state == IDLE |-> (in_valid & ~in_head) == '0);
    a_link_ch_range: assert property (@(posedge clk) disable iff (!rstn)
        link_valid |-> link_sb.ch < ch_idx_t'(CHANNELS));
    a_link_lock: assert property (@(posedge clk) disable iff (!rstn)
        (link_valid && link_sb.head && !link_sb.tail) |-> (state == LOCKED && lock_ch == link_ch));
`endif

endmodule
